receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/uart_pkg.sv | 25 ++
 rtl/bit_synchronizer.sv | 25 ++
 rtl/receiver.sv | 201 ++++++++++++++++++++
 tb/tb_receiver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: state enumeration, default oversample ratio, idle line level.
// Optional macro RX_PARITY_EN adds the PARITY state between the data bits and the stop bit.
package uart_pkg;

  localparam int   DEFAULT_OVERSAMPLE = 16;
  localparam logic RX_IDLE_LEVEL      = 1'b1;

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } rx_state_e;
`endif

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk_i domain.
// Flops reset to RESET_VAL so an idle-high line does not look like activity after reset.
module bit_synchronizer #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/receiver.sv
// Oversampling UART receiver (8 data bits, LSB first, one stop bit) with ready/overrun handshake.
// Define RX_PARITY_EN to receive and check an even-parity bit after the data bits.
module receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_100m,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] data_out,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int             TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  FULL_LAST = TW'(OVERSAMPLE - 1);

  logic rxSync;

  bit_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RX_IDLE_LEVEL)
  ) u_rxSync (
    .clk_i  (clk_100m),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rxSync)
  );

  rx_state_e     state_q,     state_d;
  logic [TW-1:0] tick_q,      tick_d;
  logic [2:0]    bitIdx_q,    bitIdx_d;
  logic [7:0]    shift_q,     shift_d;
  logic          armed_q,     armed_d;
  logic [7:0]    dataOut_q,   dataOut_d;
  logic          rdy_q,       rdy_d;
  logic          frameErr_q,  frameErr_d;
  logic          overrun_q,   overrun_d;
  logic          stopSample;
`ifdef RX_PARITY_EN
  logic          parBit_q,    parBit_d;
  logic          parityErr_q, parityErr_d;
`endif

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b0;
      dataOut_q  <= 8'h00;
      rdy_q      <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      dataOut_q  <= dataOut_d;
      rdy_q      <= rdy_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      parBit_q    <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      parBit_q    <= parBit_d;
      parityErr_q <= parityErr_d;
    end
  end
`endif

  // armed_q blocks a new start until the line has been seen idle, so a held-low break is ignored
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    stopSample = 1'b0;
`ifdef RX_PARITY_EN
    parBit_d   = parBit_q;
`endif

    if (clken) begin
      unique case (state_q)
        IDLE: begin
          if (rxSync == RX_IDLE_LEVEL) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
            tick_d  = '0;
          end
        end

        START: begin
          if (tick_q == HALF_LAST) begin
            tick_d   = '0;
            bitIdx_d = '0;
            state_d  = (rxSync == RX_IDLE_LEVEL) ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        DATA: begin
          if (tick_q == FULL_LAST) begin
            tick_d   = '0;
            shift_d  = {rxSync, shift_q[7:1]};
            bitIdx_d = bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
`ifdef RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

`ifdef RX_PARITY_EN
        PARITY: begin
          if (tick_q == FULL_LAST) begin
            tick_d   = '0;
            parBit_d = rxSync;
            state_d  = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`endif

        STOP: begin
          if (tick_q == FULL_LAST) begin
            tick_d     = '0;
            stopSample = 1'b1;
            state_d    = IDLE;
            if (rxSync != RX_IDLE_LEVEL) begin
              armed_d = 1'b0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  // A stop sample coinciding with rdy_clr keeps rdy set and does not flag overrun
  always_comb begin
    dataOut_d  = dataOut_q;
    frameErr_d = frameErr_q;
    rdy_d      = stopSample | (rdy_q & ~rdy_clr);
    overrun_d  = ~rdy_clr & (overrun_q | (stopSample & rdy_q));
`ifdef RX_PARITY_EN
    parityErr_d = parityErr_q;
`endif
    if (stopSample) begin
      dataOut_d  = shift_q;
      frameErr_d = ~rxSync;
`ifdef RX_PARITY_EN
      parityErr_d = ^{shift_q, parBit_q};
`endif
    end
  end

  assign data_out  = dataOut_q;
  assign rdy       = rdy_q;
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != IDLE);
`ifdef RX_PARITY_EN
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed scenarios plus randomized frames with gated clken.
// Expected flags come from a frame-level model (one update per transmitted frame or acknowledge).
`timescale 1ns/1ps
module tb_receiver;

  localparam int OS = 16;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk_100m = 1'b0;
  logic       rst_n    = 1'b0;
  logic       clken    = 1'b0;
  logic       rx       = 1'b1;
  logic       rdy_clr  = 1'b0;
  logic [7:0] data_out;
  logic       rdy, frame_err, overrun, parity_err, rx_busy;

  int testsRun    = 0;
  int testsFailed = 0;
  bit gateClken   = 1'b0;

  logic [7:0] mData = 8'h00;
  logic       mRdy = 1'b0, mFe = 1'b0, mOvr = 1'b0, mPe = 1'b0;

  receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk_100m   (clk_100m),
    .rst_n      (rst_n),
    .clken      (clken),
    .rx         (rx),
    .rdy_clr    (rdy_clr),
    .data_out   (data_out),
    .rdy        (rdy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk_100m = ~clk_100m;

  function automatic logic [12:0] dutStatus();
    return {data_out, rdy, frame_err, overrun, parity_err, rx_busy};
  endfunction

  function automatic logic [12:0] modelStatus();
    return {mData, mRdy, mFe, mOvr, mPe, 1'b0};
  endfunction

  // A received frame: overrun if the previous byte was still pending, then the byte is held
  task automatic modelFrame(input logic [7:0] d, input bit stopBit, input bit parBit);
    if (mRdy) mOvr = 1'b1;
    mRdy  = 1'b1;
    mData = d;
    mFe   = ~stopBit;
    mPe   = PAR_EN ? ^{d, parBit} : 1'b0;
  endtask

  task automatic advanceTicks(input int n);
    int got = 0;
    while (got < n) begin
      @(posedge clk_100m); #1;
      clken = gateClken ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (clken) got++;
    end
  endtask

  task automatic sendFrame(input logic [7:0] d, input bit stopBit, input bit parBit, input bit holdLow);
    rx = 1'b0;
    advanceTicks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      advanceTicks(OS);
    end
    if (PAR_EN) begin
      rx = parBit;
      advanceTicks(OS);
    end
    rx = stopBit;
    advanceTicks(OS);
    if (!holdLow) begin
      rx = 1'b1;
      advanceTicks(2 * OS);
    end
  endtask

  task automatic pulseClr();
    @(posedge clk_100m); #1;
    rdy_clr = 1'b1;
    @(posedge clk_100m); #1;
    rdy_clr = 1'b0;
    mRdy = 1'b0;
    mOvr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    testsRun++;
    if (dutStatus() !== 13'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got %h expected %h", dutStatus(), 13'h0);
    end
    rst_n = 1'b1;
    rx = 1'b1;
    advanceTicks(2 * OS);
    testsRun++;
    if (dutStatus() !== modelStatus()) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: got %h expected %h", dutStatus(), modelStatus());
    end
  endtask

  task automatic test_good_frame();
    sendFrame(8'h55, 1'b1, 1'b0, 1'b0);
    modelFrame(8'h55, 1'b1, 1'b0);
    testsRun++;
    if (dutStatus() !== {8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL frame_55: got %h expected %h", dutStatus(), {8'h55, 5'b10000});
    end
    pulseClr();
    testsRun++;
    if (dutStatus() !== modelStatus()) begin
      testsFailed++;
      $display("[TB] FAIL clear_55: got %h expected %h", dutStatus(), modelStatus());
    end
  endtask

  task automatic test_frame_error();
    sendFrame(8'hA3, 1'b0, ^8'hA3, 1'b1);
    modelFrame(8'hA3, 1'b0, ^8'hA3);
    advanceTicks(3 * OS);
    testsRun++;
    if (dutStatus() !== {8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL frame_err_A3_held_low: got %h expected %h", dutStatus(), {8'hA3, 5'b11000});
    end
    rx = 1'b1;
    advanceTicks(2 * OS);
    pulseClr();
    sendFrame(8'h0F, 1'b1, ^8'h0F, 1'b0);
    modelFrame(8'h0F, 1'b1, ^8'h0F);
    testsRun++;
    if (dutStatus() !== modelStatus() || frame_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL frame_0F_after_err: got %h expected %h", dutStatus(), modelStatus());
    end
    pulseClr();
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    advanceTicks(4);
    testsRun++;
    if (rx_busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL glitch_busy: got %b expected %b", rx_busy, 1'b1);
    end
    rx = 1'b1;
    advanceTicks(OS);
    testsRun++;
    if (dutStatus() !== modelStatus() || rdy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL glitch_reject: got %h expected %h", dutStatus(), modelStatus());
    end
  endtask

  task automatic test_overrun();
    sendFrame(8'h11, 1'b1, ^8'h11, 1'b0);
    modelFrame(8'h11, 1'b1, ^8'h11);
    sendFrame(8'h22, 1'b1, ^8'h22, 1'b0);
    modelFrame(8'h22, 1'b1, ^8'h22);
    testsRun++;
    if (dutStatus() !== {8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL overrun_22: got %h expected %h", dutStatus(), {8'h22, 5'b10100});
    end
    pulseClr();
    testsRun++;
    if (rdy !== 1'b0 || overrun !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL overrun_clear: got rdy=%b ovr=%b expected rdy=0 ovr=0", rdy, overrun);
    end
  endtask

  task automatic test_reset_midframe();
    sendFrame(8'h99, 1'b0, 1'b1, 1'b0);
    modelFrame(8'h99, 1'b0, 1'b1);
    rx = 1'b0;
    advanceTicks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      advanceTicks(OS);
    end
    advanceTicks(OS / 2);
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (dutStatus() !== 13'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_midframe: got %h expected %h", dutStatus(), 13'h0);
    end
    mData = 8'h00; mRdy = 1'b0; mFe = 1'b0; mOvr = 1'b0; mPe = 1'b0;
    advanceTicks(3);
    rst_n = 1'b1;
    advanceTicks(OS / 2);
    advanceTicks(2 * OS);
    testsRun++;
    if (dutStatus() !== 13'h0) begin
      testsFailed++;
      $display("[TB] FAIL no_partial_recovery: got %h expected %h", dutStatus(), 13'h0);
    end
    sendFrame(8'h3C, 1'b1, ^8'h3C, 1'b0);
    modelFrame(8'h3C, 1'b1, ^8'h3C);
    testsRun++;
    if (dutStatus() !== modelStatus() || data_out !== 8'h3C) begin
      testsFailed++;
      $display("[TB] FAIL frame_3C_after_reset: got %h expected %h", dutStatus(), modelStatus());
    end
    pulseClr();
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    sendFrame(8'h07, 1'b1, 1'b0, 1'b0);
    modelFrame(8'h07, 1'b1, 1'b0);
    testsRun++;
    if (parity_err !== 1'b1 || dutStatus() !== modelStatus()) begin
      testsFailed++;
      $display("[TB] FAIL parity_bad: got %h expected %h", dutStatus(), modelStatus());
    end
    pulseClr();
    sendFrame(8'h07, 1'b1, 1'b1, 1'b0);
    modelFrame(8'h07, 1'b1, 1'b1);
    testsRun++;
    if (parity_err !== 1'b0 || dutStatus() !== modelStatus()) begin
      testsFailed++;
      $display("[TB] FAIL parity_good: got %h expected %h", dutStatus(), modelStatus());
    end
    pulseClr();
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    bit stopBit, parBit;
    gateClken = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d       = 8'($urandom);
      stopBit = ($urandom_range(0, 4) != 0);
      parBit  = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      sendFrame(d, stopBit, parBit, 1'b0);
      modelFrame(d, stopBit, parBit);
      testsRun++;
      if (dutStatus() !== modelStatus()) begin
        testsFailed++;
        $display("[TB] FAIL random_frame_%0d: got %h expected %h", n, dutStatus(), modelStatus());
      end
      if ($urandom_range(0, 1) == 1) begin
        pulseClr();
        testsRun++;
        if (dutStatus() !== modelStatus()) begin
          testsFailed++;
          $display("[TB] FAIL random_clear_%0d: got %h expected %h", n, dutStatus(), modelStatus());
        end
      end
    end
    gateClken = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_frame_error();
    test_glitch();
    test_overrun();
    test_reset_midframe();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
